// File: rtl/iter_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned,
// results registered and held between done pulses.
//
// state | meaning
// IDLE  | waiting for start; operands sampled on the accepting edge
// RUN   | N shift-subtract iterations on the magnitudes
// FIN   | sign-correct and register results, pulse done
module iter_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem_r;
  logic [N-1:0]  quo_r;
  logic [N-1:0]  div_r;
  logic          q_neg;
  logic          r_neg;
  logic          dz_r;

  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  always_comb begin
    a_mag = (is_signed && A[N-1]) ? -A : A;
    b_mag = (is_signed && B[N-1]) ? -B : B;
  end

  // Partial remainder is kept below the divisor, so the shifted value fits N+1 bits.
  always_comb begin
    shifted = {rem_r, quo_r[N-1]};
    diff    = shifted - {1'b0, div_r};
  end

  // Divide-by-zero naturally leaves rem_r = |A|; negating it restores A, so only
  // the quotient needs forcing.
  always_comb begin
    q_fix = dz_r ? '1 : (q_neg ? -quo_r : quo_r);
    r_fix = r_neg ? -rem_r : rem_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      div_r     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz_r      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            rem_r <= '0;
            quo_r <= a_mag;
            div_r <= b_mag;
            q_neg <= is_signed & (A[N-1] ^ B[N-1]);
            r_neg <= is_signed & A[N-1];
            dz_r  <= (B == '0);
          end
        end
        RUN: begin
          if (!diff[N]) begin
            rem_r <= diff[N-1:0];
            quo_r <= {quo_r[N-2:0], 1'b1};
          end else begin
            rem_r <= shifted[N-1:0];
            quo_r <= {quo_r[N-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        FIN: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          quotient  <= q_fix;
          remainder <= r_fix;
          div_zero  <= dz_r;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed scoreboard bench for iter_divider: expected results are computed
// from native arithmetic when start is driven and compared when done pulses.
module tb_iter_divider;

  localparam int N = 32;
  localparam int LAT = N + 1;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   k_start = 0;
  exp_t exp_q[$];
  exp_t last_res = '{q: '0, r: '0, dz: 1'b0};

  iter_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .A(A), .B(B), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.q = N'(sa / sb); e.r = N'(sa % sb); e.dz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called just after a negedge; start is seen by the following posedge (edge k).
  task automatic start_op(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1; is_signed = s; A = a; B = b;
    exp_q.push_back(model(s, a, b));
    k_start = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 1);
  endtask

  task automatic wait_done(input string tag);
    bit   found = 0;
    exp_t e;
    for (int i = 0; i < 3 * LAT; i++) begin
      if (done) begin found = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, {31'b0, found}, 1);
    if (found) begin
      chk({tag, "_latency"}, N'(cyc), N'(k_start + LAT));
      chk({tag, "_busy_in_done"}, {31'b0, busy}, 0);
      chk({tag, "_queue_nonempty"}, N'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_quotient"}, quotient, e.q);
        chk({tag, "_remainder"}, remainder, e.r);
        chk({tag, "_div_zero"}, {31'b0, div_zero}, {31'b0, e.dz});
        last_res = e;
      end
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_quotient", quotient, 0);
    rst = 1'b0;
    @(negedge clk);

    start_op(0, 32'd100, 32'd7);
    wait_done("u100_7");

    start_op(1, 32'hFFFF_FFF9, 32'd2);
    wait_done("s_m7_2");
    start_op(0, 32'hFFFF_FFFF, 32'h10);
    wait_done("u_max_16");

    start_op(0, 32'd5, 32'd0);
    wait_done("u_div0");
    start_op(1, 32'd5, 32'd0);
    wait_done("s_div0");
    start_op(1, 32'd9, 32'hFFFF_FFFD);
    wait_done("s_9_m3_clears_dz");

    start_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("s_overflow");
    start_op(1, 32'hFFFF_FFEC, 32'hFFFF_FFF9);
    wait_done("s_m20_m7");

    // start while busy must be ignored; outputs hold the previous result mid-run
    start_op(0, 32'd1000, 32'd33);
    repeat (9) @(negedge clk);
    chk("hold_q_mid_run", quotient, last_res.q);
    chk("hold_r_mid_run", remainder, last_res.r);
    start = 1'b1; is_signed = 1'b1; A = 32'd77; B = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_busy_start");
    count_dones(2 * LAT, ndone);
    chk("no_extra_done", N'(ndone), 0);

    // back-to-back: start presented during the done cycle
    start_op(0, 32'd12345, 32'd100);
    wait_done("b2b_first");
    start_op(1, 32'hFFFF_F000, 32'd3);
    wait_done("b2b_second");

    // reset mid-operation
    start_op(0, 32'd999, 32'd10);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_div_zero", {31'b0, div_zero}, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    count_dones(2 * LAT, ndone);
    chk("midrst_no_done", N'(ndone), 0);

    start_op(0, 32'd81, 32'd9);
    wait_done("after_rst");

    for (int i = 0; i < 6; i++) begin
      start_op(i[0], $urandom, (i == 5) ? 32'd1 : ($urandom >> (i * 5)));
      wait_done("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
